// File: rtl/sfr_wr_if.sv
// SFR write-issue port bundle: request side from execute, hazard probe, and the
// registered SFR write bus driven by sfr_wr_issue.
`timescale 1ns/1ps
interface sfr_wr_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_type;
    logic [7:0]    req_addr;
    logic [15:0]   req_data;
    logic [7:0]    chk_addr;
    logic          chk_hit;
    logic          wr_en;
    logic          wr_bit_en;
    logic [7:0]    addr;
    logic [7:0]    data_out;
    logic          bit_out;
    logic          err_type;
    logic          empty;
    logic [CW-1:0] count;

    // master: the write-issue block itself
    modport master (
        input  req_valid, req_type, req_addr, req_data, chk_addr,
        output req_ready, chk_hit, wr_en, wr_bit_en, addr, data_out, bit_out,
               err_type, empty, count
    );

    // slave: execute/decode and the SFR blocks around it
    modport slave (
        output req_valid, req_type, req_addr, req_data, chk_addr,
        input  req_ready, chk_hit, wr_en, wr_bit_en, addr, data_out, bit_out,
               err_type, empty, count
    );
endinterface

// File: rtl/sfr_wr_issue.sv
// Queues SFR write-back requests and issues them as single-cycle byte/bit strobes;
// word requests become two byte writes (addr, addr+1). Also flags read hazards.
`timescale 1ns/1ps
module sfr_wr_issue #(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    sfr_wr_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] T_BYTE = 2'b00;
    localparam logic [1:0] T_BIT  = 2'b01;
    localparam logic [1:0] T_WORD = 2'b10;

    typedef enum logic [0:0] {ISSUE, WORD_HI} state_t;

    typedef struct packed {
        logic [1:0]  typ;
        logic [7:0]  a;
        logic [15:0] d;
    } req_t;

    req_t          fifo [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    state_t        state_q, state_d;

    logic       wr_en_q, wr_en_d;
    logic       wr_bit_en_q, wr_bit_en_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       bit_q, bit_d;
    logic       err_q, err_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] hi_addr_q, hi_addr_d;

    logic push, pop;
    req_t head;

    assign bus.req_ready = (count_q < CW'(DEPTH)) && !reset;
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = fifo[rd_ptr];

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        wr_en_d     = 1'b0;
        wr_bit_en_d = 1'b0;
        err_d       = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        bit_d       = bit_q;
        hi_d        = hi_q;
        hi_addr_d   = hi_addr_q;
        unique case (state_q)
            ISSUE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    unique case (head.typ)
                        T_BYTE: begin
                            wr_en_d = 1'b1;
                            addr_d  = head.a;
                            data_d  = head.d[7:0];
                        end
                        T_BIT: begin
                            wr_en_d     = 1'b1;
                            wr_bit_en_d = 1'b1;
                            addr_d      = head.a;
                            bit_d       = head.d[0];
                        end
                        T_WORD: begin
                            wr_en_d   = 1'b1;
                            addr_d    = head.a;
                            data_d    = head.d[7:0];
                            hi_d      = head.d[15:8];
                            hi_addr_d = head.a + 8'd1;
                            state_d   = WORD_HI;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            WORD_HI: begin
                wr_en_d = 1'b1;
                addr_d  = hi_addr_q;
                data_d  = hi_q;
                state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ISSUE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_bit_en_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            bit_q       <= 1'b0;
            err_q       <= 1'b0;
            hi_q        <= '0;
            hi_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_bit_en_q <= wr_bit_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            bit_q       <= bit_d;
            err_q       <= err_d;
            hi_q        <= hi_d;
            hi_addr_q   <= hi_addr_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: slots are only read when covered by count_q.
    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr] <= '{typ: bus.req_type, a: bus.req_addr, d: bus.req_data};
    end

    // Bit writes alias the byte whose address has bit[2:0] cleared.
    function automatic logic hit_rule(input logic [1:0] typ, input logic [7:0] a,
                                      input logic [7:0] c);
        logic [7:0] a1;
        a1 = a + 8'd1;
        case (typ)
            T_BYTE:  hit_rule = (a == c);
            T_BIT:   hit_rule = (a[7:3] == c[7:3]) && (c[2:0] == 3'd0);
            T_WORD:  hit_rule = (a == c) || (a1 == c);
            default: hit_rule = 1'b0;
        endcase
    endfunction

    always_comb begin
        logic [AW-1:0] slot;
        bus.chk_hit = 1'b0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + AW'(i);
            if ((CW'(i) < count_q) && hit_rule(fifo[slot].typ, fifo[slot].a, bus.chk_addr))
                bus.chk_hit = 1'b1;
        end
        if ((state_q == WORD_HI) && (hi_addr_q == bus.chk_addr))
            bus.chk_hit = 1'b1;
        if (wr_en_q && hit_rule(wr_bit_en_q ? T_BIT : T_BYTE, addr_q, bus.chk_addr))
            bus.chk_hit = 1'b1;
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_bit_en = wr_bit_en_q;
    assign bus.addr      = addr_q;
    assign bus.data_out  = data_q;
    assign bus.bit_out   = bit_q;
    assign bus.err_type  = err_q;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0) && (state_q == ISSUE);
endmodule

// File: tb/tb_sfr_wr_issue.sv
// Directed bench for sfr_wr_issue: every strobe is matched against a scoreboard of
// expected writes built when requests are accepted.
`timescale 1ns/1ps
module tb_sfr_wr_issue;
    localparam int DEPTH = 4;

    typedef struct {
        logic       bw;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    logic clock;
    logic reset;
    sfr_wr_if #(.DEPTH(DEPTH)) bus ();

    sfr_wr_issue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   err_seen  = 0;
    int   err_exp   = 0;
    logic prev_err  = 1'b0;
    logic full_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample just after the edge and match any strobe to the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        check("count_bound", 32'(bus.count <= DEPTH), 1);
        if (bus.err_type) begin
            err_seen++;
            check("err_no_strobe", bus.wr_en, 0);
            check("err_one_cycle", prev_err, 0);
        end
        prev_err = bus.err_type;
        if (bus.wr_en) begin
            check("strobe_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_bit_en", bus.wr_bit_en, e.bw);
                check("sb_addr", bus.addr, e.a);
                if (e.bw) check("sb_bit", bus.bit_out, e.d[0]);
                else      check("sb_data", bus.data_out, e.d);
            end
        end
    endtask

    // Present a request (valid left high) until accepted, then record its expected writes.
    task automatic send(input logic [1:0] t, input logic [7:0] a, input logic [15:0] d);
        logic acc;
        acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_data  = d;
        for (int n = 0; n < 40 && !acc; n++) begin
            acc = bus.req_ready;
            if (bus.count == DEPTH) begin
                full_seen = 1'b1;
                check("ready_low_full", bus.req_ready, 0);
            end
            step();
        end
        check("send_accepted", acc, 1);
        if (acc) begin
            case (t)
                2'b00: sb.push_back('{1'b0, a, d[7:0]});
                2'b01: sb.push_back('{1'b1, a, {7'd0, d[0]}});
                2'b10: begin
                    sb.push_back('{1'b0, a, d[7:0]});
                    sb.push_back('{1'b0, 8'(a + 8'd1), d[15:8]});
                end
                default: err_exp++;
            endcase
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (bus.empty && !bus.wr_en) break;
            step();
        end
        check("drained", bus.empty, 1);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        clock         = 1'b0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_type  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.chk_addr  = '0;
        repeat (3) step();

        check("rst_wr_en", bus.wr_en, 0);
        check("rst_bit_en", bus.wr_bit_en, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_bit", bus.bit_out, 0);
        check("rst_err", bus.err_type, 0);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_ready", bus.req_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", bus.req_ready, 1);

        // single byte: strobe one cycle after acceptance, for one cycle
        send(2'b00, 8'hE0, 16'h005A);
        bus.req_valid = 1'b0;
        check("byte_queued_no_strobe", bus.wr_en, 0);
        check("byte_count1", bus.count, 1);
        check("byte_not_empty", bus.empty, 0);
        step();
        check("byte_strobe", bus.wr_en, 1);
        check("byte_addr", bus.addr, 8'hE0);
        check("byte_data", bus.data_out, 8'h5A);
        step();
        check("byte_one_cycle", bus.wr_en, 0);
        check("byte_empty_after", bus.empty, 1);
        check("byte_addr_hold", bus.addr, 8'hE0);
        check("byte_data_hold", bus.data_out, 8'h5A);

        // bit write and its hazard on the containing byte
        bus.chk_addr = 8'hE0;
        send(2'b01, 8'hE3, 16'h0001);
        bus.req_valid = 1'b0;
        check("bit_hit_queued", bus.chk_hit, 1);
        step();
        check("bit_strobe", bus.wr_en, 1);
        check("bit_bit_en", bus.wr_bit_en, 1);
        check("bit_hit_strobing", bus.chk_hit, 1);
        step();
        check("bit_hit_after", bus.chk_hit, 0);
        check("bit_idle", bus.wr_en, 0);

        // word split followed by a byte: three consecutive strobes
        bus.chk_addr = 8'h00;
        send(2'b10, 8'h82, 16'h1234);
        send(2'b00, 8'hF0, 16'h0077);
        bus.req_valid = 1'b0;
        check("word_lo_strobe", bus.wr_en, 1);
        check("word_lo_addr", bus.addr, 8'h82);
        bus.chk_addr = 8'h83;
        #1;
        check("word_hi_hazard", bus.chk_hit, 1);
        step();
        check("word_hi_strobe", bus.wr_en, 1);
        check("word_hi_addr", bus.addr, 8'h83);
        check("word_hi_data", bus.data_out, 8'h12);
        step();
        check("word_next_strobe", bus.wr_en, 1);
        check("word_next_addr", bus.addr, 8'hF0);
        check("word_hazard_clear", bus.chk_hit, 0);
        drain();

        // word address wraps FF -> 00
        send(2'b10, 8'hFF, 16'hABCD);
        bus.req_valid = 1'b0;
        step();
        check("wrap_lo_addr", bus.addr, 8'hFF);
        step();
        check("wrap_hi_addr", bus.addr, 8'h00);
        check("wrap_hi_data", bus.data_out, 8'hAB);
        drain();

        // words slow the drain so held-valid bytes fill the queue
        for (int i = 0; i < 4; i++)
            send(2'b10, 8'(8'h10 + 2*i), 16'(16'hA000 + 16'h0101 * i));
        for (int i = 0; i < DEPTH + 2; i++)
            send(2'b00, 8'(8'h60 + i), 16'(16'h0030 + i));
        bus.req_valid = 1'b0;
        check("full_reached", full_seen, 1);
        drain();

        // reserved request between two bytes
        send(2'b00, 8'h10, 16'h0011);
        send(2'b11, 8'h20, 16'h0000);
        send(2'b00, 8'h12, 16'h0022);
        bus.req_valid = 1'b0;
        drain();
        check("err_pulses", err_seen, err_exp);

        // reset while in WORD_HI with three entries queued
        bus.chk_addr = 8'h45;
        send(2'b10, 8'h40, 16'h1111);
        send(2'b10, 8'h42, 16'h2222);
        send(2'b10, 8'h44, 16'h3333);
        send(2'b10, 8'h46, 16'h4444);
        send(2'b00, 8'h50, 16'h0055);
        send(2'b00, 8'h51, 16'h0066);
        check("pre_rst_count", bus.count, 3);
        check("pre_rst_hi_hazard", bus.chk_hit, 1);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        sb.delete();
        step();
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_count", bus.count, 0);
        check("midrst_empty", bus.empty, 1);
        check("midrst_ready", bus.req_ready, 0);
        check("midrst_hit", bus.chk_hit, 0);
        reset = 1'b0;
        #1;
        check("postrst_ready", bus.req_ready, 1);
        repeat (4) step();
        check("postrst_idle", bus.wr_en, 0);
        check("postrst_empty", bus.empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
